// File: rtl/shift_tx_sched_if.sv
// Purpose: bundles the two requester handshakes and the serial lane outputs of shift_tx_sched.
// Latency: none; this is wiring only.
// Backpressure: each requester holds reqN_valid/reqN_data until it sees reqN_ready high.
//
// Signals:
//   req0_valid/req0_data/req0_ready : requester 0 word handshake
//   req1_valid/req1_data/req1_ready : requester 1 word handshake
//   ser_out, ser_en, frame          : serial lane (bit, bit-valid, first-bit strobe)
//   busy, grant_id                  : scheduler status
// Modports: master = producer/observer side, slave = the scheduler.
interface shift_tx_sched_if #(
  parameter int WIDTH = 4
) ();

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             ser_out;
  logic             ser_en;
  logic             frame;
  logic             busy;
  logic             grant_id;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, ser_out, ser_en, frame, busy, grant_id
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, ser_out, ser_en, frame, busy, grant_id
  );

endinterface

// File: rtl/shift_tx_sched.sv
// Purpose: round-robin scheduler giving two parallel requesters one MSB-first serial lane.
// Latency: first serial bit appears the cycle after the valid&&ready edge; frames are WIDTH bits
//          followed by GAP idle cycles and one IDLE arbitration cycle.
// Backpressure: reqN_ready is only offered in IDLE to the granted requester; a requester that
//               drops valid before being granted is simply skipped.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst    : asynchronous active-high reset; aborts any frame in flight
//   tx_if  : slave modport of shift_tx_sched_if (handshakes, serial lane, status)
module shift_tx_sched #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic           clk,
  input  logic           rst,
  shift_tx_sched_if.slave tx_if
);

  // Counter widths. A zero-length gap still needs a one-bit counter so the
  // declaration stays legal; the GAP state is simply never entered then.
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? (GAP - 1) : 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;

  logic             grant0, grant1;
  logic             ready0, ready1;
  logic             in_idle, in_shift;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_shift = (state_q == ST_SHIFT);

  // Round-robin: a lone requester always wins; on a tie the one that did not
  // own the previous frame wins. Reset leaves last_grant at 1 so req0 wins first.
  assign grant0 = tx_if.req0_valid && (!tx_if.req1_valid || last_grant_q);
  assign grant1 = tx_if.req1_valid && (!tx_if.req0_valid || !last_grant_q);

  // Ready is combinational from the arbiter; it is masked by rst so nothing is
  // offered while reset is held, even though the state register already reads IDLE.
  assign ready0 = in_idle && !rst && grant0;
  assign ready1 = in_idle && !rst && grant1;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;

    case (state_q)
      ST_IDLE: begin
        // ready already implies valid, so ready alone marks the transfer edge.
        if (ready0 || ready1) begin
          shreg_d      = ready1 ? tx_if.req1_data : tx_if.req0_data;
          last_grant_d = ready1;
          grant_id_d   = ready1;
          bit_cnt_d    = '0;
          state_d      = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GCW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
    end
  end

  // Serial outputs are decoded from registered state, so they fall together
  // with the asynchronous reset and are forced low outside SHIFT.
  assign tx_if.ser_en     = in_shift;
  assign tx_if.ser_out    = in_shift && shreg_q[WIDTH-1];
  assign tx_if.frame      = in_shift && (bit_cnt_q == '0);
  assign tx_if.busy       = !in_idle;
  assign tx_if.grant_id   = grant_id_q;
  assign tx_if.req0_ready = ready0;
  assign tx_if.req1_ready = ready1;

endmodule

// File: tb/tb_shift_tx_sched.sv
`timescale 1ns/1ps
module tb_shift_tx_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_tx_sched_if #(.WIDTH(4)) a_if ();
  shift_tx_sched_if #(.WIDTH(8)) b_if ();

  shift_tx_sched #(.WIDTH(4), .GAP(1)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .tx_if (a_if)
  );

  shift_tx_sched #(.WIDTH(8), .GAP(0)) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .tx_if (b_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation mux so one set of frame tasks serves both builds.
  logic sel;
  logic s_en, s_out, s_frame, s_busy, s_gid, s_rdy0, s_rdy1;
  always_comb begin
    s_en    = sel ? b_if.ser_en     : a_if.ser_en;
    s_out   = sel ? b_if.ser_out    : a_if.ser_out;
    s_frame = sel ? b_if.frame      : a_if.frame;
    s_busy  = sel ? b_if.busy       : a_if.busy;
    s_gid   = sel ? b_if.grant_id   : a_if.grant_id;
    s_rdy0  = sel ? b_if.req0_ready : a_if.req0_ready;
    s_rdy1  = sel ? b_if.req1_ready : a_if.req1_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frame(input string tag, output int start);
    bit found;
    found = 1'b0;
    start = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (s_frame) begin
        found = 1'b1;
        start = cyc;
      end else begin
        tick();
      end
    end
    check({tag, "_frame_seen"}, {31'd0, found}, 32'd1);
  endtask

  // Called in the cycle carrying the first bit; returns in the cycle of the last bit.
  task automatic expect_frame(input string tag, input logic [7:0] word, input int nbits,
                              input logic gid);
    for (int k = 0; k < nbits; k++) begin
      if (k > 0) tick();
      check({tag, "_en"},    {31'd0, s_en},    32'd1);
      check({tag, "_bit"},   {31'd0, s_out},   {31'd0, word[nbits-1-k]});
      check({tag, "_frame"}, {31'd0, s_frame}, {31'd0, (k == 0)});
      check({tag, "_rdy"},   {30'd0, s_rdy1, s_rdy0}, 32'd0);
      if (k == 0) begin
        check({tag, "_gid"},  {31'd0, s_gid},  {31'd0, gid});
        check({tag, "_busy"}, {31'd0, s_busy}, 32'd1);
      end
    end
  endtask

  int st_prev, st_cur;
  int r1_seen, fr_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    a_if.req0_valid = 1'b0; a_if.req0_data = '0;
    a_if.req1_valid = 1'b0; a_if.req1_data = '0;
    b_if.req0_valid = 1'b0; b_if.req0_data = '0;
    b_if.req1_valid = 1'b0; b_if.req1_data = '0;
    tick(); tick();

    // Reset state, with a request already pending
    a_if.req0_valid = 1'b1; a_if.req0_data = 4'b1011;
    #1;
    check("rst_rdy0",  {31'd0, a_if.req0_ready}, 32'd0);
    check("rst_rdy1",  {31'd0, a_if.req1_ready}, 32'd0);
    check("rst_en",    {31'd0, a_if.ser_en},     32'd0);
    check("rst_out",   {31'd0, a_if.ser_out},    32'd0);
    check("rst_frame", {31'd0, a_if.frame},      32'd0);
    check("rst_busy",  {31'd0, a_if.busy},       32'd0);
    check("rst_gid",   {31'd0, a_if.grant_id},   32'd0);
    check("rst_b_en",  {31'd0, b_if.ser_en},     32'd0);

    // Single request 1011
    rst = 1'b0; #1;
    check("t1_rdy0", {31'd0, a_if.req0_ready}, 32'd1);
    check("t1_rdy1", {31'd0, a_if.req1_ready}, 32'd0);
    tick();
    a_if.req0_valid = 1'b0;
    expect_frame("t1", 8'h0B, 4, 1'b0);
    tick();
    check("t1_gap_en",   {31'd0, a_if.ser_en}, 32'd0);
    check("t1_gap_busy", {31'd0, a_if.busy},   32'd1);
    check("t1_gap_fr",   {31'd0, a_if.frame},  32'd0);
    tick();
    check("t1_idle_busy", {31'd0, a_if.busy},     32'd0);
    check("t1_idle_gid",  {31'd0, a_if.grant_id}, 32'd0);

    // Simultaneous continuous requests alternate A,5,A,5
    rst = 1'b1; tick(); rst = 1'b0;
    a_if.req0_valid = 1'b1; a_if.req0_data = 4'hA;
    a_if.req1_valid = 1'b1; a_if.req1_data = 4'h5;
    st_prev = 0;
    for (int f = 0; f < 4; f++) begin
      wait_frame("t2", st_cur);
      if (f > 0) check("t2_period", st_cur - st_prev, 32'd6);
      st_prev = st_cur;
      expect_frame("t2", (f % 2 == 0) ? 8'h0A : 8'h05, 4, (f % 2 == 1));
    end
    a_if.req0_valid = 1'b0; a_if.req1_valid = 1'b0;

    // Idle fairness: req1 alone, then both -> req0 then req1
    a_if.req1_valid = 1'b1; a_if.req1_data = 4'h3;
    wait_frame("t3a", st_cur);
    expect_frame("t3a", 8'h03, 4, 1'b1);
    a_if.req0_valid = 1'b1; a_if.req0_data = 4'hA; a_if.req1_data = 4'hC;
    wait_frame("t3b", st_cur);
    expect_frame("t3b", 8'h0A, 4, 1'b0);
    wait_frame("t3c", st_cur);
    expect_frame("t3c", 8'h0C, 4, 1'b1);
    a_if.req0_valid = 1'b0; a_if.req1_valid = 1'b0;
    tick(); tick(); tick();
    check("t3_hold_gid",  {31'd0, a_if.grant_id}, 32'd1);
    check("t3_hold_busy", {31'd0, a_if.busy},     32'd0);

    // Reset mid-frame after two bits of F
    a_if.req0_valid = 1'b1; a_if.req0_data = 4'hF;
    wait_frame("t4", st_cur);
    check("t4_b0", {31'd0, a_if.ser_out}, 32'd1);
    tick();
    check("t4_b1", {31'd0, a_if.ser_out}, 32'd1);
    rst = 1'b1; #1;
    check("t4_rst_en",   {31'd0, a_if.ser_en},     32'd0);
    check("t4_rst_fr",   {31'd0, a_if.frame},      32'd0);
    check("t4_rst_busy", {31'd0, a_if.busy},       32'd0);
    check("t4_rst_rdy",  {31'd0, a_if.req0_ready}, 32'd0);
    a_if.req0_data = 4'h6;
    a_if.req1_valid = 1'b1; a_if.req1_data = 4'h5;
    tick();
    check("t4_rst_hold_en", {31'd0, a_if.ser_en}, 32'd0);
    rst = 1'b0; #1;
    check("t4_rdy0", {31'd0, a_if.req0_ready}, 32'd1);
    check("t4_rdy1", {31'd0, a_if.req1_ready}, 32'd0);
    wait_frame("t4n", st_cur);
    expect_frame("t4n", 8'h06, 4, 1'b0);
    a_if.req0_valid = 1'b0; a_if.req1_valid = 1'b0;

    // Handshake withdrawal: req1 valid only during another frame's SHIFT
    tick(); tick();
    a_if.req0_valid = 1'b1; a_if.req0_data = 4'h9;
    wait_frame("t5", st_cur);
    a_if.req0_valid = 1'b0;
    a_if.req1_valid = 1'b1; a_if.req1_data = 4'h5;
    #1;
    check("t5_rdy1_shift", {31'd0, a_if.req1_ready}, 32'd0);
    tick(); tick();
    a_if.req1_valid = 1'b0;
    r1_seen = 0; fr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_if.req1_ready) r1_seen++;
      if (a_if.frame) fr_seen++;
    end
    check("t5_rdy1_count",  r1_seen, 32'd0);
    check("t5_frame_count", fr_seen, 32'd0);
    check("t5_gid",         {31'd0, a_if.grant_id}, 32'd0);

    // WIDTH=8, GAP=0 back-to-back 81 then 7E
    sel = 1'b1;
    b_if.req0_valid = 1'b1; b_if.req0_data = 8'h81;
    wait_frame("t6a", st_prev);
    expect_frame("t6a", 8'h81, 8, 1'b0);
    b_if.req0_data = 8'h7E;
    tick();
    check("t6_idle_en",   {31'd0, b_if.ser_en},     32'd0);
    check("t6_idle_fr",   {31'd0, b_if.frame},      32'd0);
    check("t6_idle_busy", {31'd0, b_if.busy},       32'd0);
    check("t6_idle_rdy",  {31'd0, b_if.req0_ready}, 32'd1);
    tick();
    check("t6_next_fr", {31'd0, b_if.frame}, 32'd1);
    wait_frame("t6b", st_cur);
    check("t6_period", st_cur - st_prev, 32'd9);
    b_if.req0_valid = 1'b0;
    expect_frame("t6b", 8'h7E, 8, 1'b0);
    tick();
    check("t6_end_en",   {31'd0, b_if.ser_en}, 32'd0);
    check("t6_end_busy", {31'd0, b_if.busy},   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_tx_sched.md
Name: shift_tx_sched

Overview:
- Two-requester transmit scheduler that shares one serial shift lane.
- Each requester offers a parallel WIDTH-bit word with a valid/ready handshake.
- The block arbitrates round-robin, loads the granted word into its internal shift register, and shifts it out MSB-first with bit-valid and frame strobes.
- It then enforces a programmable idle gap before the next frame. It sits between the parallel producers and the serial shift datapath.

Parameters:
- WIDTH, 4, bits per frame (serial shift chain depth); legal range ≥ 2.
- GAP, 1, idle cycles inserted after each frame; legal range ≥ 0.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- ser_out  output  1  serial data bit, MSB first.
- ser_en  output  1  ser_out carries a valid bit.
- frame  output  1  high on the first bit of each frame only.
- busy  output  1  state is not IDLE.
- grant_id  output  1  requester owning the current/last frame.

Behaviour:
- Reset is asynchronous and active-high. Reset state:
  - state = IDLE; shift register = 0; bit counter = 0; gap counter = 0.
  - last_grant = 1, so req0 wins the first tie.
  - ser_out = ser_en = frame = busy = grant_id = 0; req0_ready = req1_ready = 0.
- Reset mid-frame aborts the frame immediately. No further bits are emitted, and the word is not re-sent.
- States are IDLE, SHIFT and GAP.
- IDLE:
  - Arbitration is combinational.
  - If only one valid is high, that requester is granted.
  - If both are high, the requester that is not last_grant is granted.
  - reqN_ready = (state==IDLE) && granted N. At most one ready is high per cycle; ready is never high outside IDLE.
  - A transfer occurs on the rising edge where valid && ready. On that edge: load the shift register with the data, set last_grant and grant_id to N, clear the bit counter, and go to SHIFT.
  - Valid may drop before ready without error; the requester is then simply not granted.
  - Data is sampled only on the transfer edge.
- SHIFT:
  - Lasts exactly WIDTH cycles.
  - ser_en = 1; ser_out = shift register MSB.
  - frame = 1 only when the bit counter is 0.
  - Each edge shifts the register left with 0 fill and increments the bit counter.
  - On the edge where the bit counter equals WIDTH-1: go to GAP if GAP > 0, else to IDLE.
- GAP:
  - Lasts GAP cycles, counted by the gap counter. ser_en = 0.
  - Then go to IDLE.
- Timing and output rules:
  - Latency: the first bit appears in the cycle immediately after the transfer edge.
  - Minimum frame-to-frame period is WIDTH + GAP + 1 cycles. The +1 is the IDLE arbitration cycle.
  - ser_out and frame are 0 whenever ser_en = 0.
  - busy = 1 in SHIFT and GAP.
  - grant_id holds its value after the frame until the next transfer.
- Counters:
  - The bit counter is $clog2(WIDTH) bits wide.
  - The gap counter is $clog2(GAP+1) bits wide.
  - Neither counter wraps outside its terminal compare.
- Round-robin fairness: with both requesters continuously valid, grants alternate 0,1,0,1,… starting from 0 after reset.

Test Plan:
- Reset then single request: req0_valid=1, req0_data=4'b1011 → req0_ready high for 1 cycle. The next 4 cycles give ser_en=1 and ser_out=1,0,1,1, with frame high on cycle 1 only. This is followed by 1 GAP cycle with ser_en=0, then busy=0.
- Simultaneous requests: both valid continuously, req0=4'hA, req1=4'h5 → frames carry A,5,A,5 with grant_id 0,1,0,1. Frame starts are 6 cycles apart.
- Idle fairness: req1 alone sends 4'h3 (grant_id=1), then both go valid → req0 is granted next, then req1.
- Reset mid-frame: assert rst after 2 bits of 4'hF → ser_en, frame, busy and ready all drop to 0 asynchronously. After release, a new req0 request starts a fresh frame, and req0 wins the tie against req1.
- Handshake withdrawal: req1_valid pulses high only during SHIFT of another frame, then drops before IDLE → req1_ready never asserts and no frame for req1 is emitted.
- GAP=0, WIDTH=8 build: back-to-back req0 words 8'h81 then 8'h7E → serial 1,0,0,0,0,0,0,1 then 0,1,1,1,1,1,1,0. There is exactly one ser_en=0 cycle between the two frames.
